scan_code_sequencer: RTL
========================

Name: scan_code_sequencer

Overview:
- Generates the 3-bit channel code that drives the team's 3-to-8 one-hot decoder.
- Steps through 8 channels in round-robin order. Each enabled channel is held for a programmable dwell time; masked channels are skipped.
- Runs continuously or for a single pass, and reports frame completion.
- Typical use: multiplexed 8-digit display scanning, or 8-row keypad/sensor strobing.

Parameters:
- DWELL_CYCLES, 1000, clock cycles each channel is held; legal range 1 to 65535.
- CNT_W, 16, dwell counter width; must satisfy 2^CNT_W >= DWELL_CYCLES.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin scanning; ignored while busy.
- stop  input  1  abort scanning; has priority over start.
- mode_cont  input  1  1 = continuous scan, 0 = single pass; sampled when start is accepted.
- ch_mask  input  8  channel enable, bit i enables code i; read live at each advance.
- sel  output  3  current channel code, registered; feeds the decoder input.
- sel_valid  output  1  sel is active, so downstream should decode it.
- busy  output  1  high whenever the FSM is not in IDLE.
- frame_done  output  1  one-cycle pulse at the end of each full pass.

Behaviour:
- Reset: state IDLE; sel=3'b000; sel_valid=0; busy=0; frame_done=0; dwell counter=0; mode register=0.
- FSM states: IDLE, SCAN (plus GAP when the optional feature is compiled in).
- IDLE behaviour:
  - If start=1, stop=0 and ch_mask!=0: on the next cycle enter SCAN with sel = lowest set bit of ch_mask, counter=0, sel_valid=1, busy=1. mode_cont is latched at this point.
  - If start=1 with ch_mask=0: stay in IDLE; no pulse.
  - In IDLE, sel holds its last value and sel_valid=0.
- SCAN dwell: the counter increments each cycle. Each channel is presented for exactly DWELL_CYCLES cycles. With DWELL_CYCLES=1, the channel advances every cycle.
- Advance, taken when counter = DWELL_CYCLES-1:
  - Search upward from sel+1 to 7 for the next set mask bit; the counter resets to 0.
  - If none is found, wrap to the lowest set bit from 0. This wrap is a frame end.
- Frame end:
  - frame_done=1 for exactly one cycle, the cycle after the wrapping advance.
  - Continuous mode: scanning continues from the wrapped channel.
  - Single-pass mode: go to IDLE instead; sel holds the last channel, and sel_valid/busy fall in the same cycle frame_done rises.
- Single enabled channel: sel never changes. Every advance is a wrap, so frame_done pulses once per DWELL_CYCLES.
- Mask reads the current ch_mask at the advance:
  - If ch_mask=0 at an advance, go to IDLE with no frame_done.
  - Mask changes between advances do not affect the current dwell.
- stop=1 in any state: IDLE on the next cycle, sel_valid=0, counter cleared, no frame_done.
- start while busy: no effect.
- rst mid-scan: all outputs return to their reset values on the next edge.

Optional Feature:
- Macro: SCAN_GAP_EN.
- Defined:
  - Each advance between channels inserts one GAP cycle before the new channel's dwell; this is anti-ghosting blanking.
  - During GAP: sel_valid=0, busy=1, sel already shows the next code.
  - The new channel then dwells for DWELL_CYCLES cycles.
  - On a continuous-mode wrap, frame_done coincides with the GAP cycle.
  - A single-pass end enters IDLE directly, with no GAP.
  - stop during GAP goes to IDLE.
- Undefined: the GAP state does not exist, and channels are back-to-back as described above.

Test Plan:
- Continuous scan, DWELL_CYCLES=4, mask=8'hFF, mode_cont=1, start pulse -> sel runs 0,1,…,7,0, each for 4 cycles with sel_valid=1. frame_done pulses once, in the first cycle of the second sel=0 dwell (cycle 33 after start is accepted).
- Skip mask 8'b1010_0100, single pass -> sel sequence is 2,5,7 (4 cycles each). Then IDLE with sel=7, sel_valid=0, busy=0, and a single frame_done in the first IDLE cycle.
- Single channel, mask=8'h08, continuous -> sel stays 3 and frame_done pulses every 4 cycles. Then clear the mask to 0 -> IDLE at the next advance with no frame_done.
- Stop and start at the same time, mid-scan at sel=5 -> IDLE next cycle, sel_valid=0, no frame_done. A later start pulse resumes from the lowest enabled channel. Start with mask=0 -> stays IDLE.
- Reset mid-dwell (rst high for 1 cycle) -> sel=0, sel_valid=0, busy=0, frame_done=0 on the next edge. Counter restarts from 0 after a new start.
- With SCAN_GAP_EN, mask=8'h03, continuous -> sel_valid pattern is 4 high, 1 low, repeating. frame_done coincides with the GAP cycle before each return to sel=0.

Source files
------------

// File: rtl/scan_code_sequencer.sv
// -----------------------------------------------------------------------------
// scan_code_sequencer
//
// Purpose:
//    Generates the 3-bit channel code for a 3-to-8 one-hot decoder. The eight
//    channels are visited in ascending round-robin order. Each channel enabled
//    in ch_mask is held for DWELL_CYCLES clocks, and masked channels are
//    skipped. Scanning is either continuous or a single pass. Each completed
//    pass is reported with a one-cycle frame_done pulse.
//
// Build option:
//    SCAN_GAP_EN  When this macro is defined, one blanking (GAP) cycle is
//                 inserted before every new channel dwell. During GAP,
//                 sel_valid is low and sel already shows the next code. A
//                 single-pass end goes straight to IDLE with no GAP. When the
//                 macro is undefined, channels run back to back.
//
// Parameters:
//    DWELL_CYCLES  clocks each channel is held (1 .. 65535)
//    CNT_W         dwell counter width, 2**CNT_W >= DWELL_CYCLES
//
// Ports:
//    clk         in   system clock, rising edge
//    rst         in   synchronous active-high reset
//    start       in   single-cycle scan request, ignored while busy
//    stop        in   abort scanning, has priority over start
//    mode_cont   in   1 = continuous, 0 = single pass (latched at start)
//    ch_mask     in   [7:0] channel enables, read live at each advance
//    sel         out  [2:0] registered channel code for the decoder
//    sel_valid   out  sel should be decoded
//    busy        out  FSM is not idle
//    frame_done  out  one-cycle pulse at the end of each full pass
// -----------------------------------------------------------------------------
module scan_code_sequencer #(
   parameter int DWELL_CYCLES = 1000,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       mode_cont,
   input  logic [7:0] ch_mask,
   output logic [2:0] sel,
   output logic       sel_valid,
   output logic       busy,
   output logic       frame_done
);

`ifdef SCAN_GAP_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Every channel change passes through one blanking cycle first.
   localparam state_t LP_ADV_STATE = ST_GAP;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1
   } state_t;

   localparam state_t LP_ADV_STATE = ST_SCAN;
`endif

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

   // -------------------------------------------------------------------------
   // Channel search helpers
   // -------------------------------------------------------------------------

   // Index of the lowest set bit. The result is only meaningful when
   // mask != 0, and callers check that first.
   function automatic logic [2:0] f_lowest(input logic [7:0] mask);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // True when some enabled channel lies strictly above cur.
   function automatic logic f_has_above(input logic [7:0] mask,
                                        input logic [2:0] cur);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (mask[i] && (i > int'(cur))) hit = 1'b1;
      end
      return hit;
   endfunction

   // Lowest enabled channel strictly above cur. It returns cur when no such
   // channel exists, and callers gate it with f_has_above.
   function automatic logic [2:0] f_next_above(input logic [7:0] mask,
                                               input logic [2:0] cur);
      logic [2:0] idx;
      idx = cur;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i] && (i > int'(cur))) idx = 3'(i);
      end
      return idx;
   endfunction

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   state_t           r_state;
   logic [2:0]       r_sel;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mode;
   logic             r_frame_done;

   state_t           w_state_nxt;
   logic [2:0]       w_sel_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_mode_nxt;
   logic             w_frame_done_nxt;
   logic             w_dwell_end;
   logic             w_mask_any;
   logic             w_has_above;
   logic [2:0]       w_next_above;
   logic [2:0]       w_lowest;

   assign w_dwell_end  = (r_cnt == LP_CNT_LAST);
   assign w_mask_any   = (ch_mask != 8'h00);
   assign w_has_above  = f_has_above(ch_mask, r_sel);
   assign w_next_above = f_next_above(ch_mask, r_sel);
   assign w_lowest     = f_lowest(ch_mask);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_sel        <= 3'd0;
         r_cnt        <= '0;
         r_mode       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sel        <= w_sel_nxt;
         r_cnt        <= w_cnt_nxt;
         r_mode       <= w_mode_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and next-value logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      w_sel_nxt        = r_sel;
      w_cnt_nxt        = r_cnt;
      w_mode_nxt       = r_mode;
      w_frame_done_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            // A start with an empty mask is dropped, because there is
            // nothing to scan.
            if (start && !stop && w_mask_any) begin
               w_state_nxt = ST_SCAN;
               w_sel_nxt   = w_lowest;
               w_mode_nxt  = mode_cont;
            end
         end

         ST_SCAN: begin
            if (stop) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (w_dwell_end) begin
               w_cnt_nxt = '0;
               if (!w_mask_any) begin
                  // All channels disabled mid-scan: quiet abort, no frame end.
                  w_state_nxt = ST_IDLE;
               end else if (w_has_above) begin
                  w_sel_nxt   = w_next_above;
                  w_state_nxt = LP_ADV_STATE;
               end else begin
                  // Wrap past channel 7, which ends the frame.
                  w_frame_done_nxt = 1'b1;
                  if (r_mode) begin
                     w_sel_nxt   = w_lowest;
                     w_state_nxt = LP_ADV_STATE;
                  end else begin
                     // Single pass: sel keeps showing the last channel.
                     w_state_nxt = ST_IDLE;
                  end
               end
            end else begin
               w_cnt_nxt = r_cnt + LP_CNT_ONE;
            end
         end

`ifdef SCAN_GAP_EN
         ST_GAP: begin
            // sel already holds the upcoming code. The dwell starts at zero
            // on the next cycle.
            w_cnt_nxt   = '0;
            w_state_nxt = stop ? ST_IDLE : ST_SCAN;
         end
`endif

         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign sel        = r_sel;
   assign sel_valid  = (r_state == ST_SCAN);
   assign busy       = (r_state != ST_IDLE);
   assign frame_done = r_frame_done;

endmodule
